mixcolumns_serial: RTL and testbench
====================================

// Module: mixcolumns_serial
// PURPOSE
//  Byte-serial AES MixColumns stage. It sits directly downstream of shiftrows in the optimised datapath.
//  It collects each 4-byte state column, in column-major order row0..row3, from the shiftrows byte stream.
//  It applies the GF(2^8) column mix (or InvMixColumns, or pass-through on the final round).
//  It re-emits the column one byte per cycle, overlapping collection of the next column with emission of the current one.
// PARAMETERS
//  INV_MIX  0  0: MixColumns coeffs {02,03,01,01}; 1: InvMixColumns coeffs {0e,0b,0d,09}
// PORTS
//  clock      in   1  rising-edge clock
//  resetn     in   1  asynchronous, active-low reset
//  enable     in   1  inbyte valid; byte sampled on rising edge when high
//  lastround  in   1  bypass mix for this column; sampled with the column's 4th byte
//  inbyte     in   8  input state byte from shiftrows
//  outbyte    out  8  output state byte
//  ready      out  1  outbyte valid this cycle
// BEHAVIOUR
//  Reset (resetn low, async): in_cnt=0, out_cnt=0, ready=0, outbyte=8'h00, column buffers cleared.
//  Input side:
//   - 2-bit in_cnt counts accepted bytes (row index) and holds while enable is low.
//   - Rows 0..2 are stored in hold regs a0..a2.
//   - On the edge accepting row 3, the column {a0,a1,a2,inbyte} is mixed combinationally.
//   - The 4 results load the output buffer o0..o3; in_cnt wraps 3->0.
//  Mix arithmetic:
//   - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
//   - MixColumns: d_r = 02*s_r ^ 03*s_(r+1) ^ s_(r+2) ^ s_(r+3), indices mod 4.
//   - InvMixColumns: coeffs 0e,0b,0d,09 in the same rotation, built from chained xtime. No multipliers, no tables.
//   - lastround=1: d_r = s_r (pass-through).
//  Output FSM, states IDLE, EMIT:
//   - IDLE: ready=0. A column load moves to EMIT with out_cnt=0.
//   - EMIT: outbyte=o[out_cnt], ready=1, out_cnt increments each cycle, independent of enable.
//   - After o3: if a new column loads on that same edge, stay in EMIT with out_cnt=0; else go to IDLE.
//  Latency: d0 is on outbyte/ready the cycle after the edge that samples s3. d1..d3 follow on consecutive cycles.
//  Throughput: 1 byte/cycle sustained; a continuous 16-byte block yields 16 contiguous ready cycles.
//  Overflow is impossible: a column needs at least 4 input cycles and emission takes exactly 4. No backpressure port.
//  Input gaps (enable low mid-column): partial column held; output may go idle between columns.
//  Simultaneous load and final emit: the new column wins; o0..o3 overwrite with no bubble.
//  Reset mid-column or mid-emission: partial data discarded; ready drops immediately. The next accepted byte is row 0.
//  outbyte is registered and holds its last value when ready=0.
// TESTING
//  1. INV_MIX=0, enable held, bytes d4,bf,5d,30 -> ready for 4 cycles starting 1 cycle after 30 is sampled, outbyte 04,66,81,e5.
//  2. FIPS-197 round-1 state after ShiftRows, 16 contiguous bytes (d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5)
//     -> 16 contiguous ready cycles: 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c.
//  3. Known columns db,13,53,45 -> 8e,4d,a1,bc; f2,0a,22,5c -> 9f,dc,58,9d; c6 x4 -> c6 x4; 01 x4 -> 01 x4.
//  4. lastround=1 with column 2b,7e,15,16 -> outputs 2b,7e,15,16 unchanged; lastround=0 on the next column resumes mixing.
//  5. Gaps: enable low for 3 cycles between rows 1 and 2 of column d4,bf,5d,30 -> still 04,66,81,e5; ready low until 1 cycle after 30.
//  6. resetn low for one cycle after 2 bytes, then column db,13,53,45 -> ready=0 immediately; output 8e,4d,a1,bc with no stale data.
//     Also run an INV_MIX=1 build with 04,66,81,e5 -> d4,bf,5d,30.

Source files
------------

// File: rtl/mixcolumns_serial.sv
// mixcolumns_serial: byte-serial AES MixColumns / InvMixColumns stage.
// Collects one 4-byte column (row0..row3), mixes it when the last row is
// accepted and re-emits the result one byte per cycle. Collection of the
// next column overlaps emission of the current one.
module mixcolumns_serial #(
    parameter int unsigned INV_MIX = 0  // 0: MixColumns, 1: InvMixColumns
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       lastround,
    input  logic [7:0] inbyte,
    output logic [7:0] outbyte,
    output logic       ready
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // GF(2^8) helpers, all built from xtime (no multipliers, no tables)
    // ---------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul03(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [1:0] in_cnt_q,  in_cnt_d;
    logic [7:0] hold_q [3];
    logic [7:0] hold_d [3];
    logic [7:0] obuf_q [4];
    logic [7:0] obuf_d [4];
    logic [1:0] out_cnt_q, out_cnt_d;
    state_t     state_q,   state_d;
    logic [7:0] outbyte_q, outbyte_d;

    logic       col_load;
    logic [7:0] col    [4];
    logic [7:0] mixed  [4];
    logic [1:0] nxt_idx;

    // Input side: count rows, park rows 0..2, flag the row-3 edge as a load
    always_comb begin
        in_cnt_d = in_cnt_q;
        hold_d   = hold_q;
        col_load = 1'b0;
        if (enable) begin
            in_cnt_d = in_cnt_q + 2'd1;
            case (in_cnt_q)
                2'd0:    hold_d[0] = inbyte;
                2'd1:    hold_d[1] = inbyte;
                2'd2:    hold_d[2] = inbyte;
                default: col_load  = 1'b1;
            endcase
        end
    end

    // Column mix of {a0,a1,a2,inbyte}; pass-through when lastround is set
    always_comb begin
        col[0] = hold_q[0];
        col[1] = hold_q[1];
        col[2] = hold_q[2];
        col[3] = inbyte;
        for (int unsigned r = 0; r < 4; r++) begin
            mixed[r] = 8'h00;
            if (lastround) begin
                mixed[r] = col[r];
            end else if (INV_MIX != 0) begin
                mixed[r] = mul0e(col[r])           ^ mul0b(col[(r + 1) % 4]) ^
                           mul0d(col[(r + 2) % 4]) ^ mul09(col[(r + 3) % 4]);
            end else begin
                mixed[r] = xtime(col[r])  ^ mul03(col[(r + 1) % 4]) ^
                           col[(r + 2) % 4] ^ col[(r + 3) % 4];
            end
        end
    end

    // Output FSM next state: a load always wins and restarts emission at d0.
    // outbyte is registered, so d0 is loaded straight from the mix result on
    // the load edge and later bytes come from the buffer one index ahead.
    always_comb begin
        state_d   = state_q;
        out_cnt_d = out_cnt_q;
        outbyte_d = outbyte_q;
        obuf_d    = obuf_q;
        nxt_idx   = out_cnt_q + 2'd1;
        if (col_load) begin
            obuf_d    = mixed;
            outbyte_d = mixed[0];
            out_cnt_d = 2'd0;
            state_d   = EMIT;
        end else begin
            case (state_q)
                EMIT: begin
                    if (out_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        out_cnt_d = nxt_idx;
                        outbyte_d = obuf_q[nxt_idx];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            state_q   <= IDLE;
            outbyte_q <= '0;
            for (int unsigned i = 0; i < 3; i++) hold_q[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) obuf_q[i] <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            state_q   <= state_d;
            outbyte_q <= outbyte_d;
            for (int unsigned i = 0; i < 3; i++) hold_q[i] <= hold_d[i];
            for (int unsigned i = 0; i < 4; i++) obuf_q[i] <= obuf_d[i];
        end
    end

    assign outbyte = outbyte_q;
    assign ready   = (state_q == EMIT);

endmodule

// File: tb/tb_mixcolumns_serial.sv
// tb_mixcolumns_serial: directed checks of the byte-serial MixColumns stage,
// forward build plus an InvMixColumns build fed the same input stream.
module tb_mixcolumns_serial;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable;
    logic       lastround;
    logic [7:0] inbyte;
    logic [7:0] out_f, out_i;
    logic       rdy_f, rdy_i;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [7:0] blk_in  [16];
    logic [7:0] blk_exp [16];

    always #5 clock = ~clock;

    mixcolumns_serial #(.INV_MIX(0)) u_fwd (
        .clock(clock), .resetn(resetn), .enable(enable), .lastround(lastround),
        .inbyte(inbyte), .outbyte(out_f), .ready(rdy_f)
    );

    mixcolumns_serial #(.INV_MIX(1)) u_inv (
        .clock(clock), .resetn(resetn), .enable(enable), .lastround(lastround),
        .inbyte(inbyte), .outbyte(out_i), .ready(rdy_i)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    endtask

    // One clock: drive inputs at the falling edge, let the rising edge sample
    // them, then compare outputs at the next falling edge.
    task automatic cyc(input logic en, input logic [7:0] b, input logic last,
                       input bit inv, input logic exp_rdy, input logic [7:0] exp_out,
                       input string tag);
        enable    = en;
        inbyte    = b;
        lastround = last;
        @(posedge clock);
        @(negedge clock);
        check({tag, " ready"}, {7'h0, (inv ? rdy_i : rdy_f)}, {7'h0, exp_rdy});
        if (exp_rdy) check({tag, " outbyte"}, (inv ? out_i : out_f), exp_out);
    endtask

    // Contiguous 16-byte stream: output k appears after the edge sampling input k+3
    task automatic stream16(input string tag);
        int unsigned j;
        for (int i = 0; i < 16; i++) begin
            j = (i >= 3) ? i - 3 : 0;
            cyc(1'b1, blk_in[i], 1'b0, 1'b0, (i >= 3), blk_exp[j], tag);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, blk_exp[13 + i], tag);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, {tag, " end"});
    endtask

    initial begin
        resetn    = 1'b0;
        enable    = 1'b0;
        lastround = 1'b0;
        inbyte    = 8'h00;
        repeat (2) @(negedge clock);
        check("reset ready fwd", {7'h0, rdy_f}, 8'h00);
        check("reset out fwd",   out_f,         8'h00);
        check("reset ready inv", {7'h0, rdy_i}, 8'h00);
        check("reset out inv",   out_i,         8'h00);
        resetn = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "idle");

        // single column, ready exactly 4 cycles starting after 30 is sampled
        cyc(1'b1, 8'hd4, 1'b0, 1'b0, 1'b0, 8'h00, "t1 r0");
        cyc(1'b1, 8'hbf, 1'b0, 1'b0, 1'b0, 8'h00, "t1 r1");
        cyc(1'b1, 8'h5d, 1'b0, 1'b0, 1'b0, 8'h00, "t1 r2");
        cyc(1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h04, "t1 d0");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, "t1 d1");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81, "t1 d2");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'he5, "t1 d3");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "t1 idle");
        check("t1 hold", out_f, 8'he5);

        // FIPS-197 round 1 state after ShiftRows
        blk_in  = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                    8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
        blk_exp = '{8'h04, 8'h66, 8'h81, 8'he5, 8'he0, 8'hcb, 8'h19, 8'h9a,
                    8'h48, 8'hf8, 8'hd3, 8'h7a, 8'h28, 8'h06, 8'h26, 8'h4c};
        stream16("t2");

        // known columns
        blk_in  = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
                    8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h01, 8'h01, 8'h01, 8'h01};
        blk_exp = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d,
                    8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h01, 8'h01, 8'h01, 8'h01};
        stream16("t3");

        // lastround bypass on the 4th byte; set on a row-0 byte it has no effect
        cyc(1'b1, 8'h2b, 1'b0, 1'b0, 1'b0, 8'h00, "t4 r0");
        cyc(1'b1, 8'h7e, 1'b0, 1'b0, 1'b0, 8'h00, "t4 r1");
        cyc(1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 8'h00, "t4 r2");
        cyc(1'b1, 8'h16, 1'b1, 1'b0, 1'b1, 8'h2b, "t4 p0");
        cyc(1'b1, 8'hdb, 1'b1, 1'b0, 1'b1, 8'h7e, "t4 p1");
        cyc(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h15, "t4 p2");
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 8'h16, "t4 p3");
        cyc(1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 8'h8e, "t4 m0");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4d, "t4 m1");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'ha1, "t4 m2");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hbc, "t4 m3");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "t4 idle");

        // enable gap of 3 cycles between rows 1 and 2
        cyc(1'b1, 8'hd4, 1'b0, 1'b0, 1'b0, 8'h00, "t5 r0");
        cyc(1'b1, 8'hbf, 1'b0, 1'b0, 1'b0, 8'h00, "t5 r1");
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'hee, 1'b0, 1'b0, 1'b0, 8'h00, "t5 gap");
        cyc(1'b1, 8'h5d, 1'b0, 1'b0, 1'b0, 8'h00, "t5 r2");
        cyc(1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h04, "t5 d0");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, "t5 d1");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81, "t5 d2");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'he5, "t5 d3");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "t5 idle");

        // reset mid-emission and mid-column
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hc6, 1'b0, 1'b0, 1'b0, 8'h00, "t6 pre");
        cyc(1'b1, 8'hc6, 1'b0, 1'b0, 1'b1, 8'hc6, "t6 e0");
        cyc(1'b1, 8'hdb, 1'b0, 1'b0, 1'b1, 8'hc6, "t6 e1");
        cyc(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'hc6, "t6 e2");
        resetn = 1'b0;
        #1;
        check("t6 async ready", {7'h0, rdy_f}, 8'h00);
        check("t6 async out",   out_f,         8'h00);
        enable = 1'b1;
        inbyte = 8'hff;
        @(posedge clock);
        @(negedge clock);
        check("t6 held ready", {7'h0, rdy_f}, 8'h00);
        resetn = 1'b1;
        cyc(1'b1, 8'hdb, 1'b0, 1'b0, 1'b0, 8'h00, "t6 r0");
        cyc(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 8'h00, "t6 r1");
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 1'b0, 8'h00, "t6 r2");
        cyc(1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 8'h8e, "t6 d0");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4d, "t6 d1");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'ha1, "t6 d2");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hbc, "t6 d3");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "t6 idle");

        // InvMixColumns build undoes the forward mix
        cyc(1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h00, "t7 r0");
        cyc(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00, "t7 r1");
        cyc(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 8'h00, "t7 r2");
        cyc(1'b1, 8'he5, 1'b0, 1'b1, 1'b1, 8'hd4, "t7 d0");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hbf, "t7 d1");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5d, "t7 d2");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h30, "t7 d3");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, "t7 idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
